// File: rtl/multicycle_control.sv
// multicycle_control: main sequencing FSM for the multi-cycle MIPS datapath.
// A single memory and ALU are time-shared across fetch, decode, execute,
// memory and writeback steps. All datapath controls are decoded from the
// current state. The PC/IR load in FETCH and the PC load in BRANCH also look
// at this cycle's inputs. Strobes are forced low whenever reset is high, so
// an instruction cut short by reset never writes anything.
module multicycle_control #(
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] inst_31_26,
   input  logic       mem_ready,
   input  logic       zero,
   output logic       pc_write,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic [1:0] pc_source,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      R_EXEC   = 4'd6,
      I_EXEC   = 4'd7,
      ALU_WB   = 4'd8,
      BRANCH   = 4'd9,
      JUMP     = 4'd10,
      TRAP     = 4'd11
   } state_t;

   state_t     state_q;
   state_t     state_next;
   logic [5:0] op_q;
   logic       illegal_q;
   logic       rdy;

   // With the handshake disabled, every memory access completes in one cycle.
   assign rdy        = MEM_HANDSHAKE ? mem_ready : 1'b1;
   assign state      = state_q;
   assign illegal_op = illegal_q;

   // Next-state selection. Decode dispatches on the live IR opcode. Later
   // states use the opcode captured while in DECODE.
   always_comb begin
      state_next = state_q;
      case (state_q)
         FETCH:    if (rdy) state_next = DECODE;
         DECODE: begin
            case (inst_31_26)
               6'd0:                                  state_next = R_EXEC;
               6'd35, 6'd43:                          state_next = MEM_ADDR;
               6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15: state_next = I_EXEC;
               6'd4, 6'd5:                            state_next = BRANCH;
               6'd2, 6'd3:                            state_next = JUMP;
               default:                               state_next = TRAP;
            endcase
         end
         MEM_ADDR: begin
            if (op_q == 6'd35)      state_next = MEM_RD;
            else if (op_q == 6'd43) state_next = MEM_WR;
            else                    state_next = TRAP;
         end
         MEM_RD:   if (rdy) state_next = MEM_WB;
         MEM_WB:   state_next = FETCH;
         MEM_WR:   if (rdy) state_next = FETCH;
         R_EXEC:   state_next = ALU_WB;
         I_EXEC:   state_next = ALU_WB;
         ALU_WB:   state_next = FETCH;
         BRANCH:   state_next = FETCH;
         JUMP:     state_next = FETCH;
         TRAP:     state_next = TRAP;
         default:  state_next = TRAP;
      endcase
   end

   // State, captured opcode and sticky illegal flag. Reset overrides everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FETCH;
         op_q      <= 6'd0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_next;
         if (state_q == DECODE) op_q <= inst_31_26;
         if (state_next == TRAP) illegal_q <= 1'b1;
      end
   end

   // Datapath controls decoded from the current state. Strobes are gated off by reset.
   always_comb begin
      pc_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 3'b000;
      pc_source  = 2'b00;
      instr_done = 1'b0;
      case (state_q)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = rdy;
            pc_write  = rdy;
         end
         DECODE: begin
            alu_src_b = 2'b11;
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         MEM_WB: begin
            mem_to_reg = 2'b01;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         MEM_WR: begin
            mem_write  = 1'b1;
            iord       = 1'b1;
            instr_done = rdy;
         end
         R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 3'b010;
         end
         I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            case (op_q)
               6'd12:   alu_op = 3'b011;
               6'd13:   alu_op = 3'b100;
               6'd10:   alu_op = 3'b101;
               6'd14:   alu_op = 3'b110;
               6'd15:   alu_op = 3'b111;
               default: alu_op = 3'b000;
            endcase
         end
         ALU_WB: begin
            reg_write  = 1'b1;
            reg_dst    = (op_q == 6'd0) ? 2'b01 : 2'b00;
            instr_done = 1'b1;
         end
         BRANCH: begin
            alu_src_a  = 1'b1;
            alu_op     = 3'b001;
            pc_source  = 2'b01;
            pc_write   = (op_q == 6'd5) ? ~zero : zero;
            instr_done = 1'b1;
         end
         JUMP: begin
            pc_source  = 2'b10;
            pc_write   = 1'b1;
            instr_done = 1'b1;
            if (op_q == 6'd3) begin
               reg_dst    = 2'b10;
               mem_to_reg = 2'b10;
               reg_write  = 1'b1;
            end
         end
         default: begin
         end
      endcase
      if (reset) begin
         pc_write   = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         instr_done = 1'b0;
      end
   end

endmodule
